// File: rtl/timer_regs_pkg.sv
// Register map, control bits and FSM states shared by the timer tick master.
// Word addresses of the SoC interval timer, control word layout, helpers.
// Imported by the interface-level master and its bench.
package timer_regs_pkg;

  // Timer word addresses (16-bit registers).
  typedef enum logic [3:0] {
    REG_STATUS  = 4'd0,
    REG_CONTROL = 4'd1,
    REG_PERIOD0 = 4'd2,
    REG_PERIOD1 = 4'd3,
    REG_PERIOD2 = 4'd4,
    REG_PERIOD3 = 4'd5,
    REG_SNAP0   = 4'd6,
    REG_SNAP1   = 4'd7,
    REG_SNAP2   = 4'd8,
    REG_SNAP3   = 4'd9
  } reg_addr_e;

  // Control register bit positions.
  localparam int CTRL_ITO_BIT   = 0;
  localparam int CTRL_CONT_BIT  = 1;
  localparam int CTRL_START_BIT = 2;
  localparam int CTRL_STOP_BIT  = 3;

  typedef enum logic [3:0] {
    ST_IDLE, ST_WP0, ST_WP1, ST_WP2, ST_WP3, ST_WCTL, ST_RUN,
    ST_ACK, ST_STOP, ST_SNW, ST_SNR0, ST_SNR1, ST_SNR2
  } state_e;

  // A zero load value would give a degenerate 1-cycle interval; use 1 instead.
  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

  function automatic logic [15:0] ctrl_word(input logic ito, input logic cont,
                                            input logic start, input logic stop);
    logic [15:0] w;
    w = 16'd0;
    w[CTRL_ITO_BIT]   = ito;
    w[CTRL_CONT_BIT]  = cont;
    w[CTRL_START_BIT] = start;
    w[CTRL_STOP_BIT]  = stop;
    return w;
  endfunction

endpackage

// File: rtl/timer_tick_master_if.sv
// Avalon-MM link between the tick master and the interval timer.
// No waitrequest: every access completes in the cycle it is driven.
// Read data returns one cycle after the address; irq is a level.
interface timer_tick_master_if;
  logic [3:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  logic        timer_irq;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata, timer_irq
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata, timer_irq
  );
endinterface

// File: rtl/timer_tick_master.sv
// Programs the interval timer, services its timeouts as tick pulses, reads snapshots.
// Start write lands 5 cycles after cfg accept; tick appears in the cycle of the status write.
// cfg_ready only in IDLE; stop/snap levels are honoured only in RUN, irq wins over both.
module timer_tick_master
  import timer_regs_pkg::*;
#(
  parameter bit CTRL_ITO = 1'b1,
  parameter int TICK_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [31:0]       cfg_period,
  input  logic              cfg_continuous,
  input  logic              stop_req,
  input  logic              snap_req,
  output logic              snap_valid,
  output logic [31:0]       snap_value,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic              busy,
  timer_tick_master_if.master avm
);

  state_e      state;
  logic [31:0] period_q;
  logic        cont_q;

  assign cfg_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  // Single FSM; bus outputs are registered so each state's access is driven while in that state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= ST_IDLE;
      period_q           <= 32'd0;
      cont_q             <= 1'b0;
      tick               <= 1'b0;
      tick_count         <= '0;
      snap_valid         <= 1'b0;
      snap_value         <= 32'd0;
      avm.avm_chipselect <= 1'b0;
      avm.avm_write_n    <= 1'b1;
      avm.avm_address    <= 4'd0;
      avm.avm_writedata  <= 16'd0;
    end else begin
      // Idle bus and no pulses unless the transition below says otherwise.
      avm.avm_chipselect <= 1'b0;
      avm.avm_write_n    <= 1'b1;
      avm.avm_address    <= 4'd0;
      avm.avm_writedata  <= 16'd0;
      tick               <= 1'b0;
      snap_valid         <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_valid) begin
            period_q           <= clamp_period(cfg_period);
            cont_q             <= cfg_continuous;
            tick_count         <= '0;
            state              <= ST_WP0;
            avm.avm_chipselect <= 1'b1;
            avm.avm_write_n    <= 1'b0;
            avm.avm_address    <= REG_PERIOD0;
            avm.avm_writedata  <= clamp_period(cfg_period) >> 0 & 32'h0000_FFFF;
          end
        end
        ST_WP0: begin
          state              <= ST_WP1;
          avm.avm_chipselect <= 1'b1;
          avm.avm_write_n    <= 1'b0;
          avm.avm_address    <= REG_PERIOD1;
          avm.avm_writedata  <= period_q[31:16];
        end
        ST_WP1: begin
          state              <= ST_WP2;
          avm.avm_chipselect <= 1'b1;
          avm.avm_write_n    <= 1'b0;
          avm.avm_address    <= REG_PERIOD2;
        end
        ST_WP2: begin
          state              <= ST_WP3;
          avm.avm_chipselect <= 1'b1;
          avm.avm_write_n    <= 1'b0;
          avm.avm_address    <= REG_PERIOD3;
        end
        ST_WP3: begin
          state              <= ST_WCTL;
          avm.avm_chipselect <= 1'b1;
          avm.avm_write_n    <= 1'b0;
          avm.avm_address    <= REG_CONTROL;
          avm.avm_writedata  <= ctrl_word(CTRL_ITO, cont_q, 1'b1, 1'b0);
        end
        ST_WCTL: state <= ST_RUN;
        ST_RUN: begin
          if (avm.timer_irq) begin
            // Clearing the timeout and the tick share one cycle.
            state              <= ST_ACK;
            tick               <= 1'b1;
            tick_count         <= tick_count + 1'b1;
            avm.avm_chipselect <= 1'b1;
            avm.avm_write_n    <= 1'b0;
            avm.avm_address    <= REG_STATUS;
          end else if (stop_req) begin
            state              <= ST_STOP;
            avm.avm_chipselect <= 1'b1;
            avm.avm_write_n    <= 1'b0;
            avm.avm_address    <= REG_CONTROL;
            avm.avm_writedata  <= ctrl_word(1'b0, 1'b0, 1'b0, 1'b1);
          end else if (snap_req) begin
            state              <= ST_SNW;
            avm.avm_chipselect <= 1'b1;
            avm.avm_write_n    <= 1'b0;
            avm.avm_address    <= REG_SNAP0;
          end
        end
        ST_ACK:  state <= cont_q ? ST_RUN : ST_IDLE;
        ST_STOP: state <= ST_IDLE;
        ST_SNW: begin
          state              <= ST_SNR0;
          avm.avm_chipselect <= 1'b1;
          avm.avm_address    <= REG_SNAP0;
        end
        ST_SNR0: begin
          state              <= ST_SNR1;
          avm.avm_chipselect <= 1'b1;
          avm.avm_address    <= REG_SNAP1;
        end
        ST_SNR1: begin
          // Data for the SNAP0 read issued last cycle.
          snap_value[15:0] <= avm.avm_readdata;
          state            <= ST_SNR2;
        end
        ST_SNR2: begin
          snap_value[31:16] <= avm.avm_readdata;
          snap_valid        <= 1'b1;
          state             <= ST_RUN;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_tick_master.sv
// Bench for timer_tick_master with a behavioural interval-timer model on the bus.
// Expected ticks and snapshots come from period arithmetic relative to the start write.
// Bus accesses, ticks and snapshots are logged at the falling edge and checked later.
module tb_timer_tick_master;

  logic        clk = 1'b0;
  logic        reset, tm_rst;
  logic        cfg_valid, cfg_continuous, stop_req, snap_req, force_irq;
  logic [31:0] cfg_period;
  logic        cfg_ready, snap_valid, tick, busy;
  logic [31:0] snap_value;
  logic [15:0] tick_count;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  timer_tick_master_if bus();

  timer_tick_master #(.CTRL_ITO(1'b1), .TICK_W(16)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_period(cfg_period),
    .cfg_continuous(cfg_continuous), .stop_req(stop_req), .snap_req(snap_req),
    .snap_valid(snap_valid), .snap_value(snap_value), .tick(tick),
    .tick_count(tick_count), .busy(busy), .avm(bus)
  );

  // ---------------- interval timer model ----------------
  logic [15:0] tm_per [4];
  logic [31:0] tm_cnt, tm_snap;
  logic        tm_run, tm_cont, tm_ito, tm_to;
  wire  [31:0] tm_period = {tm_per[1], tm_per[0]};

  assign bus.timer_irq = (tm_to && tm_ito) || force_irq;

  always @(posedge clk or posedge tm_rst) begin
    if (tm_rst) begin
      for (int i = 0; i < 4; i++) tm_per[i] <= 16'd0;
      tm_cnt <= 0; tm_snap <= 0; tm_run <= 0; tm_cont <= 0; tm_ito <= 0; tm_to <= 0;
      bus.avm_readdata <= 16'd0;
    end else begin
      if (tm_run) begin
        if (tm_cnt == 0) begin
          tm_cnt <= tm_period;
          tm_to  <= 1'b1;
          if (!tm_cont) tm_run <= 1'b0;
        end else begin
          tm_cnt <= tm_cnt - 1;
        end
      end
      if (bus.avm_chipselect && !bus.avm_write_n) begin
        case (bus.avm_address)
          4'd0: tm_to <= 1'b0;
          4'd1: begin
            tm_ito  <= bus.avm_writedata[0];
            tm_cont <= bus.avm_writedata[1];
            if (bus.avm_writedata[2]) begin tm_run <= 1'b1; tm_cnt <= tm_period; end
            if (bus.avm_writedata[3]) tm_run <= 1'b0;
          end
          4'd2, 4'd3, 4'd4, 4'd5: begin
            tm_per[bus.avm_address - 4'd2] <= bus.avm_writedata;
            tm_run <= 1'b0;
          end
          4'd6, 4'd7, 4'd8, 4'd9: tm_snap <= tm_cnt;
          default: ;
        endcase
      end
      if (bus.avm_chipselect && bus.avm_write_n)
        bus.avm_readdata <= (bus.avm_address == 4'd6) ? tm_snap[15:0] :
                            (bus.avm_address == 4'd7) ? tm_snap[31:16] : 16'd0;
    end
  end

  // ---------------- monitor ----------------
  typedef struct { int cyc; logic wr; logic [3:0] addr; logic [15:0] data; } acc_t;
  acc_t        bus_log[$];
  int          tick_log[$];
  logic [31:0] snap_log[$];

  always @(negedge clk) begin
    if (bus.avm_chipselect)
      bus_log.push_back('{cyc: cyc, wr: !bus.avm_write_n, addr: bus.avm_address,
                          data: bus.avm_writedata});
    if (tick) tick_log.push_back(cyc);
    if (snap_valid) snap_log.push_back(snap_value);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Lands just after the falling edge, after the monitor has logged that cycle.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  function automatic logic [20:0] bus_at(input int c);
    foreach (bus_log[i])
      if (bus_log[i].cyc == c) return {bus_log[i].wr, bus_log[i].addr, bus_log[i].data};
    return 21'h0;
  endfunction

  function automatic logic [31:0] clamp(input logic [31:0] p);
    return (p == 0) ? 32'd1 : p;
  endfunction

  // Expected snapshot: counter holds P right after the start write and steps down by one
  // per cycle modulo P+1; the SNW write visible at cycle w captures it on the next edge.
  function automatic logic [31:0] exp_snap(input int s, input int w, input int p);
    return p - ((w - s - 1) % (p + 1));
  endfunction

  task automatic clear_logs();
    bus_log.delete(); tick_log.delete(); snap_log.delete();
  endtask

  task automatic start_cfg(input logic [31:0] p, input logic c, output int acc);
    cfg_period = p; cfg_continuous = c; cfg_valid = 1'b1;
    for (int i = 0; i < 40 && !cfg_ready; i++) step();
    if (!cfg_ready) chk("cfg_ready_wait", cfg_ready, 1);
    acc = cyc;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic check_cfg_writes(input int a, input logic [31:0] p, input logic c);
    logic [31:0] pp;
    pp = clamp(p);
    wait_until(a + 6);
    chk("cfgw_p0",  bus_at(a + 1), {1'b1, 4'd2, pp[15:0]});
    chk("cfgw_p1",  bus_at(a + 2), {1'b1, 4'd3, pp[31:16]});
    chk("cfgw_p2",  bus_at(a + 3), {1'b1, 4'd4, 16'h0000});
    chk("cfgw_p3",  bus_at(a + 4), {1'b1, 4'd5, 16'h0000});
    chk("cfgw_ctl", bus_at(a + 5), {1'b1, 4'd1, c ? 16'h0007 : 16'h0005});
    chk("cnt_clr",  tick_count, 0);
  endtask

  task automatic wait_ticks(input int n, input int budget);
    for (int i = 0; i < budget && tick_log.size() < n; i++) step();
    if (tick_log.size() < n) chk("tick_wait", tick_log.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) step();
    chk("idle", busy, 0);
  endtask

  task automatic do_snap(input int s, input int p);
    int n0, b0, w;
    logic [20:0] r;
    n0 = snap_log.size(); b0 = bus_log.size(); w = -1;
    snap_req = 1'b1;
    for (int i = 0; i < 30 && w < 0; i++) begin
      step();
      for (int j = b0; j < bus_log.size(); j++)
        if (w < 0 && bus_log[j].wr && bus_log[j].addr == 4'd6) w = bus_log[j].cyc;
    end
    snap_req = 1'b0;
    chk("snw_seen", (w >= 0), 1);
    for (int i = 0; i < 20 && snap_log.size() == n0; i++) step();
    repeat (5) step();
    chk("snap_pulses", snap_log.size(), n0 + 1);
    r = bus_at(w + 1);
    chk("snr_addr6", r[20:16], 5'h06);
    r = bus_at(w + 2);
    chk("snr_addr7", r[20:16], 5'h07);
    if (snap_log.size() > n0) chk("snap_value", snap_log[n0], exp_snap(s, w, p));
  endtask

  task automatic do_stop();
    int b0;
    b0 = bus_log.size();
    stop_req = 1'b1;
    for (int i = 0; i < 20 && busy; i++) step();
    stop_req = 1'b0;
    step();
    chk("stop_idle", busy, 0);
    chk("stop_nacc", bus_log.size() - b0, 1);
    if (bus_log.size() > b0)
      chk("stop_write", {bus_log[b0].wr, bus_log[b0].addr, bus_log[b0].data}, {1'b1, 4'd1, 16'h0008});
  endtask

  // Irq seen outside RUN must produce neither a tick nor bus traffic.
  task automatic idle_irq_check();
    int b0, t0;
    logic [15:0] c0;
    b0 = bus_log.size(); t0 = tick_log.size(); c0 = tick_count;
    force_irq = 1'b1;
    repeat (10) step();
    force_irq = 1'b0;
    repeat (5) step();
    chk("idle_irq_bus", bus_log.size() - b0, 0);
    chk("idle_irq_tick", tick_log.size() - t0, 0);
    chk("idle_irq_cnt", tick_count, c0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int a, s, x, nt, p, np, e;
    logic c;
    reset = 1'b1; tm_rst = 1'b1;
    cfg_valid = 0; cfg_continuous = 0; cfg_period = 0;
    stop_req = 0; snap_req = 0; force_irq = 0;
    repeat (3) step();
    chk("rst_cs",    bus.avm_chipselect, 0);
    chk("rst_wn",    bus.avm_write_n, 1);
    chk("rst_addr",  bus.avm_address, 0);
    chk("rst_wdat",  bus.avm_writedata, 0);
    chk("rst_tick",  tick, 0);
    chk("rst_snapv", snap_valid, 0);
    chk("rst_snap",  snap_value, 0);
    chk("rst_cnt",   tick_count, 0);
    chk("rst_busy",  busy, 0);
    reset = 1'b0; tm_rst = 1'b0;
    step();
    chk("rst_ready", cfg_ready, 1);

    // Reset while the third period write is on the bus.
    start_cfg(32'h0001_0040, 1'b1, a);
    wait_until(a + 3);
    chk("wp2_live", {bus.avm_chipselect, !bus.avm_write_n, bus.avm_address}, {2'b11, 4'd4});
    reset = 1'b1;
    #1;
    chk("arst_cs",   bus.avm_chipselect, 0);
    chk("arst_wn",   bus.avm_write_n, 1);
    chk("arst_addr", bus.avm_address, 0);
    chk("arst_wdat", bus.avm_writedata, 0);
    chk("arst_busy", busy, 0);
    step();
    reset = 1'b0;
    step();
    chk("arst_ready", cfg_ready, 1);

    // Long continuous period: write sequence and first tick exactly one period later.
    clear_logs();
    start_cfg(32'h0000_C34F, 1'b1, a);
    check_cfg_writes(a, 32'h0000_C34F, 1'b1);
    s = a + 5;
    wait_ticks(1, 50100);
    if (tick_log.size() > 0) chk("c34f_tick", tick_log[0], s + 2 + 50000);
    chk("c34f_cnt", tick_count, 1);
    step();
    chk("c34f_ack", bus_at(s + 2 + 50000), {1'b1, 4'd0, 16'h0000});
    do_stop();

    // One-shot, period 9.
    clear_logs();
    start_cfg(32'd9, 1'b0, a);
    check_cfg_writes(a, 32'd9, 1'b0);
    s = a + 5;
    wait_ticks(1, 40);
    if (tick_log.size() > 0) chk("os_tick", tick_log[0], s + 12);
    step();
    chk("os_ack", bus_at(s + 12), {1'b1, 4'd0, 16'h0000});
    wait_idle(5);
    repeat (20) step();
    chk("os_nticks", tick_log.size(), 1);
    chk("os_cnt", tick_count, 1);
    idle_irq_check();

    // Continuous period 99: snapshot mid-period, then irq and snap together.
    clear_logs();
    start_cfg(32'd99, 1'b1, a);
    check_cfg_writes(a, 32'd99, 1'b1);
    s = a + 5;
    wait_until(s + 41);
    do_snap(s, 99);
    x = -1;
    for (int i = 0; i < 200 && x < 0; i++) begin
      if (bus.timer_irq) x = cyc; else step();
    end
    chk("irq_seen", (x >= 0), 1);
    nt = tick_log.size();
    do_snap(s, 99);
    chk("coinc_ntick", tick_log.size(), nt + 1);
    if (tick_log.size() > nt) chk("coinc_tick", tick_log[nt], x + 1);
    wait_ticks(3, 400);
    chk("p99_cnt3", tick_count, 3);
    if (tick_log.size() > 2) chk("p99_tick3", tick_log[2], s + 2 + 3 * 100);
    wait_until(s + 2 + 3 * 100 + 50);
    do_stop();
    idle_irq_check();

    // Randomized periods, modes and snapshot times.
    for (int it = 0; it < 6; it++) begin
      p = $urandom_range(24, 80);
      c = 1'($urandom_range(0, 1));
      np = $urandom_range(2, 4);
      clear_logs();
      start_cfg(p, c, a);
      check_cfg_writes(a, p, c);
      s = a + 5;
      if (!c) begin
        wait_ticks(1, p + 20);
        if (tick_log.size() > 0) chk("rnd_os_tick", tick_log[0], s + p + 3);
        wait_idle(5);
        chk("rnd_os_cnt", tick_count, 1);
      end else begin
        e = s + 2 + np * (p + 1) + p / 2;
        while (cyc + 30 < e) begin
          if ($urandom_range(0, p / 2) == 0) do_snap(s, p);
          else step();
        end
        wait_until(e);
        do_stop();
        chk("rnd_cnt", tick_count, np);
        chk("rnd_nticks", tick_log.size(), np);
        foreach (tick_log[k])
          chk("rnd_tick_lag", (tick_log[k] >= s + 2 + (k + 1) * (p + 1)) &&
                              (tick_log[k] <= s + 7 + (k + 1) * (p + 1)), 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_tick_master.md
Name: timer_tick_master

Overview:
- Avalon-MM initiator that programs and services the SoC interval timer (16-bit data, 4-bit word address, registers 0–9) without CPU involvement.
- Loads a period, starts the timer in one-shot or continuous mode and acknowledges each timeout interrupt.
- Emits one-cycle tick pulses to the synthesizer voice/envelope logic, keeps a tick count, and on request reads back a 32-bit counter snapshot.

Parameters:
- CTRL_ITO, 1, drives the interrupt-enable bit (control bit 0) on start writes.
- TICK_W, 16, width of tick_count.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cfg_valid  in  1  start request; period and mode are valid
- cfg_ready  out  1  high only in IDLE; transfer occurs when cfg_valid && cfg_ready
- cfg_period  in  32  timer load value; tick interval = cfg_period+1 clk cycles
- cfg_continuous  in  1  1 = continuous, 0 = one-shot
- stop_req  in  1  level; honoured in RUN
- snap_req  in  1  level; honoured in RUN
- snap_valid  out  1  one-cycle pulse; snap_value is valid
- snap_value  out  32  captured counter snapshot
- tick  out  1  one-cycle pulse per serviced timeout
- tick_count  out  TICK_W  number of ticks since the last cfg accept; wraps
- busy  out  1  state != IDLE
- avm_address  out  4  timer word address
- avm_chipselect  out  1  asserted for every access
- avm_write_n  out  1  active-low write strobe
- avm_writedata  out  16  write data
- avm_readdata  in  16  timer read data, registered, valid one cycle after address
- timer_irq  in  1  timer interrupt, level

Behaviour:
- Reset values: all Avalon outputs registered; chipselect=0, write_n=1, address=0, writedata=0. tick=0, snap_valid=0, snap_value=0, tick_count=0, state=IDLE.
- Reset mid-operation: abort to IDLE immediately; the timer is not touched. The next cfg period write stops the timer through its force-reload.
- Bus rule: the timer has no waitrequest, so every write completes in its cycle. Idle cycles drive chipselect=0, write_n=1.
- cfg_period==0 is clamped to 1.
- States: IDLE, WP0, WP1, WP2, WP3, WCTL, RUN, ACK, STOP, SNW, SNR0, SNR1, SNR2.
- IDLE: on cfg handshake, latch period and mode, clear tick_count, go to WP0.
- WP0..WP3: write addr 2..5 with data period[15:0], period[31:16], 0, 0 (one cycle each).
- WCTL: write addr 1, data {12'b0, 1'b0 STOP, 1'b1 START, continuous, CTRL_ITO}. Continuous gives 0x0007 and one-shot 0x0005 (ITO=1). Then go to RUN.
- Start latency: the start write occurs 5 cycles after the accept cycle.
- RUN priority, highest first:
  - timer_irq → ACK
  - stop_req → STOP
  - snap_req → SNW
  - otherwise hold
- ACK: write addr 0, data 0, which clears the timeout; irq drops the following cycle. In the same cycle: tick=1, tick_count+1. Then go to RUN if continuous, else IDLE.
- STOP: write addr 1, data 0x0008. Then IDLE. A pending irq is dropped.
- SNW: write addr 6, data 0, to capture the counter.
- SNR0: read addr 6 (chipselect=1, write_n=1).
- SNR1: read addr 7; capture readdata → snap_value[15:0].
- SNR2: capture readdata → snap_value[31:16]; pulse snap_valid; return to RUN.
- An irq arriving during the snap sequence stays high (level) and is serviced on return to RUN; no tick is lost.
- cfg_valid outside IDLE is ignored (cfg_ready=0).
- stop_req or snap_req outside RUN is ignored.

Decomposition:
- Shared package (timer_regs_pkg): register word addresses (STATUS=0, CONTROL=1, PERIOD0..3=2..5, SNAP0..3=6..9), control bit positions (ITO=0, CONT=1, START=2, STOP=3) and the state enum.
- Single module; no sub-module is warranted.

Test Plan:
- Reset mid-WP2 → outputs return to their reset values immediately; cfg_ready=1 after reset is released.
- cfg_period=0x0000C34F, continuous: writes observed as (2,C34F), (3,0000), (4,0000), (5,0000), (1,0007) on consecutive cycles. With the paired timer model, tick appears every 50000 cycles and tick_count=3 after 3 periods.
- One-shot, period=9 → exactly one tick ~10 cycles after start, status write (0,0000), then busy=0. tick_count stays 1 with irq left asserted afterwards.
- Continuous period=99, snap_req at cycle 40 of a period → writes (6,xxxx), reads addr 6 then 7. snap_value equals the model counter at the SNW edge (≤99), with a single snap_valid pulse.
- timer_irq and snap_req rise in the same RUN cycle → ACK first (tick), then the snap sequence; no extra or missing tick.
- stop_req in RUN → single write (1,0008), then IDLE. Later irq pulses produce no tick and no bus activity.
